lu_cache_reader: RTL
====================

# lu_cache_reader

Read-out engine for the `LU_cache` block. On a `start` pulse it snapshots the cache's full cell array (`data_out` of `LU_cache`) and streams the cells one per beat over a valid/ready handshake, tagged with the cell index. It then signals completion. It sits between the cache and any downstream consumer (UART transmitter, debug port, checker) that cannot take the whole array in parallel.

## Interface
- `CELL_SIZE`, default 8: width of one cache cell in bits.
- `CELL_COUNT`, default 8: number of cells in the cache.
- `CELL_ADDR_SIZE`, default 3: index width. Must be ≥ clog2(`CELL_COUNT`).

Ports:
- `clk`  in  1: single clock; all logic on the rising edge.
- `reset`  in  1: synchronous, active-low reset.
- `cache_data`  in  `CELL_COUNT*CELL_SIZE`: flattened cache array. Cell i is at bits [i*`CELL_SIZE` +: `CELL_SIZE`], which matches `LU_cache` `data_out` packed as [`CELL_COUNT`-1:0][`CELL_SIZE`-1:0].
- `start`  in  1: request a read-out. Sampled only in IDLE.
- `data_out`  out  `CELL_SIZE`: current cell value.
- `addr_out`  out  `CELL_ADDR_SIZE`: index of the current cell.
- `valid`  out  1: `data_out`/`addr_out` hold a beat.
- `ready`  in  1: consumer accepts the beat.
- `busy`  out  1: high from the first cycle after `start` is accepted until the cycle after `done`.
- `done`  out  1: one-cycle pulse after the last beat is accepted.

## Operation
- State machine: IDLE, SEND, DONE.
- **IDLE**
  - `valid`=0, `busy`=0, `done`=0.
  - When `start`=1 at an edge: latch all of `cache_data` into an internal snapshot register, set index=0, go to SEND.
- **SEND**
  - `valid`=1, `busy`=1, `data_out`=snapshot[index], `addr_out`=index.
  - A beat transfers at an edge where `valid` && `ready`.
  - On transfer with index < `CELL_COUNT`-1: index+1, stay in SEND.
  - On transfer with index = `CELL_COUNT`-1: go to DONE. The index does not wrap to a new beat.
  - Without transfer: all outputs hold exactly, with no change in `data_out` or `addr_out`.
- **DONE**
  - `valid`=0, `done`=1, `busy`=1 for exactly one cycle, then go to IDLE unconditionally.
- `start` in SEND or DONE is ignored. It is not queued.
- The snapshot is frozen during SEND. Changes to `cache_data` after the `start` edge never appear in the stream.
- Cells are emitted in ascending index order 0 .. `CELL_COUNT`-1, always all of them. Zero-valued cells are emitted too.
- `CELL_COUNT` does not need to be a power of two. The index compares against `CELL_COUNT`-1, not against counter overflow.
- `ready` may be high in IDLE or DONE. It has no effect there.

## Timing
- Reset (`reset`=0 at an edge) forces:
  - state IDLE, index 0;
  - `valid`=0, `busy`=0, `done`=0;
  - `data_out`=0, `addr_out`=0;
  - snapshot cleared to 0.
- Reset takes priority over `start` and `ready` in the same cycle.
- Reset during SEND or DONE aborts the read-out. No `done` pulse is produced. The next `start` restarts from cell 0 with a fresh snapshot.
- Latency: `start` sampled at edge N gives `valid`=1 with cell 0 during cycle N+1.
- With `ready` held high, one beat transfers per cycle. The last beat transfers at edge N+`CELL_COUNT`. `done`=1 during cycle N+`CELL_COUNT`+1. The block is back in IDLE (and `start` is accepted again) at edge N+`CELL_COUNT`+2.
- Total occupancy is `CELL_COUNT`+2 cycles plus any `ready`-low stall cycles.
- All outputs are registered. There is no combinational path from `ready` or `start` to any output.

## Test plan
- **Basic stream:** `CELL_COUNT`=8, `CELL_SIZE`=8, cells 0..7 = 9,1,2,4,5,6,7,8, `ready`=1, `start` pulse.
  - Required: beats (addr,data) = (0,9),(1,1),...,(7,8) on 8 consecutive cycles starting 1 cycle after `start`.
  - Then `done` high for 1 cycle; `busy` high for 9 cycles total.
- **Backpressure:** same data, `ready` toggles 1,0,0,1,...
  - Required: during `ready`=0 cycles, `valid` stays 1 with `data_out` and `addr_out` unchanged.
  - Every cell is delivered exactly once, in order.
- **Snapshot:** start with cells all 0x11; change `cache_data` to all 0xEE one cycle after `start`.
  - Required: all 8 beats carry 0x11.
- **Ignored start:** pulse `start` during cell 3 and again during the `done` cycle.
  - Required: the stream is unaffected, and exactly one `done` pulse occurs.
  - A second read-out happens only after a `start` issued in IDLE.
- **Reset mid-operation:** drive `reset`=0 for 1 cycle after cell 4 is accepted.
  - Required: next cycle `valid`=0, `busy`=0, `done`=0, `data_out`=0, `addr_out`=0, and no `done` pulse.
  - A new `start` then streams from addr 0.
- **Non-power-of-two:** `CELL_COUNT`=5, `CELL_ADDR_SIZE`=3.
  - Required: exactly addresses 0..4 are emitted, then `done`.
  - Address 5 never appears.

Source files
------------

// File: rtl/lu_cache_reader_if.sv
// Beat stream from lu_cache_reader to its consumer: one cache cell per
// valid/ready transfer, tagged with the cell index.
interface lu_cache_reader_if #(
    parameter int CELL_SIZE      = 8,
    parameter int CELL_ADDR_SIZE = 3
);
    logic [CELL_SIZE-1:0]      data_out;
    logic [CELL_ADDR_SIZE-1:0] addr_out;
    logic                      valid;
    logic                      ready;

    modport master (output data_out, output addr_out, output valid, input ready);
    modport slave  (input data_out, input addr_out, input valid, output ready);
endinterface

// File: rtl/lu_cache_reader.sv
// Snapshots the LU_cache cell array on start and streams it out one cell per
// valid/ready beat in ascending index order, then pulses done.
module lu_cache_reader #(
    parameter int CELL_SIZE      = 8,
    parameter int CELL_COUNT     = 8,
    parameter int CELL_ADDR_SIZE = 3
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [CELL_COUNT*CELL_SIZE-1:0] cache_data,
    input  logic                           start,
    output logic                           busy,
    output logic                           done,
    lu_cache_reader_if.master              strm
);
    typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

    // Compare against the real last index so non-power-of-two counts stop cleanly.
    localparam logic [CELL_ADDR_SIZE-1:0] LAST_IDX = CELL_ADDR_SIZE'(CELL_COUNT - 1);

    state_t                                   state, state_d;
    logic [CELL_ADDR_SIZE-1:0]                idx, idx_d;
    logic [CELL_COUNT-1:0][CELL_SIZE-1:0]     snap, snap_d;

    logic                      valid_d, busy_d, done_d;
    logic [CELL_SIZE-1:0]      data_d;
    logic [CELL_ADDR_SIZE-1:0] addr_d;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= IDLE;
            idx           <= '0;
            snap          <= '0;
            strm.valid    <= 1'b0;
            strm.data_out <= '0;
            strm.addr_out <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            state         <= state_d;
            idx           <= idx_d;
            snap          <= snap_d;
            strm.valid    <= valid_d;
            strm.data_out <= data_d;
            strm.addr_out <= addr_d;
            busy          <= busy_d;
            done          <= done_d;
        end
    end

    always_comb begin
        state_d = state;
        idx_d   = idx;
        snap_d  = snap;
        case (state)
            IDLE: begin
                if (start) begin
                    snap_d  = cache_data;
                    idx_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                // valid is always high in SEND, so ready alone marks a transfer.
                if (strm.ready) begin
                    if (idx == LAST_IDX) state_d = DONE;
                    else                 idx_d   = idx + CELL_ADDR_SIZE'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are computed from the next state so they come straight off flops.
    always_comb begin
        valid_d = (state_d == SEND);
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == DONE);
        data_d  = '0;
        addr_d  = '0;
        if (valid_d) begin
            data_d = snap_d[idx_d];
            addr_d = idx_d;
        end
    end
endmodule
